// File: rtl/edge_period_meter_if.sv
// Measurement bundle from edge_period_meter to its consumers
// (display refresh, scan logic, divider self-check).
interface edge_period_meter_if #(
  parameter int PERIOD_WIDTH = 24
);
  logic                    level;
  logic                    rise_tick;
  logic                    fall_tick;
  logic [PERIOD_WIDTH-1:0] period;
  logic                    period_valid;
  logic                    locked;
  logic                    stalled;

  modport master (
    output level, rise_tick, fall_tick, period, period_valid, locked, stalled
  );

  modport slave (
    input level, rise_tick, fall_tick, period, period_valid, locked, stalled
  );
endinterface

// File: rtl/edge_period_meter.sv
// Synchronises a slow asynchronous square wave into the system clock
// domain, emits rise/fall ticks, measures the rising-edge period in
// system cycles and flags a stall when the input stops toggling.
//
// state  | meaning
// IDLE   | no reference edge yet (after reset or after a stall)
// ARMED  | one rising edge seen, counting towards the first period
// LOCKED | two or more consecutive rising edges seen, period is live
module edge_period_meter #(
  parameter int SYNC_STAGES  = 2,
  parameter int PERIOD_WIDTH = 24,
  parameter int TIMEOUT      = 2**22
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                slow_in,
  edge_period_meter_if.master meas
);

  typedef enum logic [1:0] {IDLE, ARMED, LOCKED} state_t;

  // Counter value on the last cycle before a missing edge becomes a stall.
  localparam logic [PERIOD_WIDTH-1:0] CNT_LAST = PERIOD_WIDTH'(TIMEOUT - 1);

  state_t                  state;
  state_t                  state_nxt;
  logic [SYNC_STAGES-1:0]  sync;
  logic                    prev;
  logic                    rise_tick_q;
  logic                    fall_tick_q;
  logic [PERIOD_WIDTH-1:0] cnt;
  logic [PERIOD_WIDTH-1:0] period_q;
  logic                    period_valid_q;
  logic                    stalled_q;
  logic                    level;
  logic                    rise;
  logic                    fall;
  logic                    timeout;
  logic                    load_period;
  logic                    set_stall;

  assign level   = sync[SYNC_STAGES-1];
  assign rise    = level & ~prev;
  assign fall    = ~level & prev;
  assign timeout = (state != IDLE) && (cnt == CNT_LAST);

  // Synchroniser chain, previous-level flop and registered edge ticks.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      sync        <= '0;
      prev        <= 1'b0;
      rise_tick_q <= 1'b0;
      fall_tick_q <= 1'b0;
    end else begin
      sync        <= {sync[SYNC_STAGES-2:0], slow_in};
      prev        <= level;
      rise_tick_q <= rise;
      fall_tick_q <= fall;
    end
  end

  // FSM state register.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next state; a rise in the timeout cycle takes priority over the stall.
  always_comb begin
    state_nxt   = state;
    load_period = 1'b0;
    set_stall   = 1'b0;
    unique case (state)
      IDLE: begin
        if (rise) state_nxt = ARMED;
      end
      ARMED: begin
        if (rise) begin
          state_nxt   = LOCKED;
          load_period = 1'b1;
        end else if (timeout) begin
          state_nxt = IDLE;
          set_stall = 1'b1;
        end
      end
      LOCKED: begin
        if (rise) begin
          load_period = 1'b1;
        end else if (timeout) begin
          state_nxt = IDLE;
          set_stall = 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Cycle counter, period capture and sticky stall flag; all update with rise_tick.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      cnt            <= '0;
      period_q       <= '0;
      period_valid_q <= 1'b0;
      stalled_q      <= 1'b0;
    end else begin
      // The edge cycle itself counts towards the period, hence cnt+1.
      if (rise || state_nxt == IDLE) cnt <= '0;
      else                           cnt <= cnt + PERIOD_WIDTH'(1);
      if (load_period) period_q <= cnt + PERIOD_WIDTH'(1);
      period_valid_q <= load_period;
      if (rise)           stalled_q <= 1'b0;
      else if (set_stall) stalled_q <= 1'b1;
    end
  end

  assign meas.level        = level;
  assign meas.rise_tick    = rise_tick_q;
  assign meas.fall_tick    = fall_tick_q;
  assign meas.period       = period_q;
  assign meas.period_valid = period_valid_q;
  assign meas.locked       = (state == LOCKED);
  assign meas.stalled      = stalled_q;

endmodule

// File: tb/tb_edge_period_meter.sv
// Bench for edge_period_meter: a history-based reference model predicts every
// output each cycle; scenario tasks add the directed edge-timing checks.
module tb_edge_period_meter;
  localparam int SYNC_STAGES = 2;
  localparam int PW          = 24;
  localparam int TIMEOUT     = 64;

  logic clock   = 1'b0;
  logic reset   = 1'b0;
  logic slow_in = 1'b0;

  int n_tests = 0;
  int n_fail  = 0;

  edge_period_meter_if #(.PERIOD_WIDTH(PW)) meas();

  edge_period_meter #(
    .SYNC_STAGES (SYNC_STAGES),
    .PERIOD_WIDTH(PW),
    .TIMEOUT     (TIMEOUT)
  ) dut (
    .clock  (clock),
    .reset  (reset),
    .slow_in(slow_in),
    .meas   (meas)
  );

  always #5 clock = ~clock;

  // Reference model: outputs derived from the history of sampled inputs,
  // the list of rising-edge times and the timeout rule.
  bit          hist[int];
  int          e_cnt;
  int          last_rise;
  int          nrise;
  logic        exp_level, exp_rise, exp_fall, exp_pv, exp_locked, exp_stalled;
  logic [PW-1:0] exp_period;

  function automatic logic smp(input int k);
    return (k >= 1 && hist.exists(k)) ? hist[k] : 1'b0;
  endfunction

  initial begin
    e_cnt = 0; last_rise = 0; nrise = 0;
    exp_level = 0; exp_rise = 0; exp_fall = 0; exp_pv = 0;
    exp_locked = 0; exp_stalled = 0; exp_period = '0;
    forever begin
      @(posedge clock or negedge reset);
      if (!reset) begin
        hist.delete();
        e_cnt = 0; last_rise = 0; nrise = 0;
        exp_level = 0; exp_rise = 0; exp_fall = 0; exp_pv = 0;
        exp_locked = 0; exp_stalled = 0; exp_period = '0;
      end else begin
        e_cnt++;
        hist[e_cnt] = slow_in;
        if (hist.exists(e_cnt - 4)) hist.delete(e_cnt - 4);
        // level follows the input one edge late; ticks compare two older samples
        exp_level = smp(e_cnt - 1);
        exp_rise  = smp(e_cnt - 2) & ~smp(e_cnt - 3);
        exp_fall  = ~smp(e_cnt - 2) & smp(e_cnt - 3);
        exp_pv    = 1'b0;
        if (exp_rise) begin
          if (nrise > 0) begin
            exp_period = PW'(e_cnt - last_rise);
            exp_pv     = 1'b1;
          end
          nrise++;
          last_rise   = e_cnt;
          exp_stalled = 1'b0;
        end else if (nrise > 0 && e_cnt - last_rise == TIMEOUT) begin
          nrise       = 0;
          exp_stalled = 1'b1;
        end
        exp_locked = (nrise >= 2);
      end
    end
  end

  // Drive one input sample and land 1 time unit after the edge that takes it.
  task automatic step(input logic v);
    slow_in = v;
    @(posedge clock);
    #1;
  endtask

  task automatic test_reset();
    logic [5:0] got;
    reset = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step(i[0]);
      got = {meas.level, meas.rise_tick, meas.fall_tick, meas.period_valid, meas.locked, meas.stalled};
      n_tests++;
      if (got !== 6'b0 || meas.period !== '0) begin
        n_fail++;
        $display("FAIL reset_outputs cyc=%0d got %b/%0d required 000000/0", i, got, meas.period);
      end
    end
  endtask

  task automatic test_lock();
    logic [5:0] got, want;
    bit lv[$];
    int rise_c[$];
    int fall_c[$];
    int c = 0;
    int first_high = -1;
    for (int i = 0; i < 2; i++) lv.push_back(1'b0);
    for (int p = 0; p < 4; p++)
      for (int i = 0; i < 8; i++) lv.push_back(i < 4);
    reset = 1'b1;
    foreach (lv[k]) begin
      c++;
      if (lv[k] && first_high < 0) first_high = c;
      step(lv[k]);
      got  = {meas.level, meas.rise_tick, meas.fall_tick, meas.period_valid, meas.locked, meas.stalled};
      want = {exp_level, exp_rise, exp_fall, exp_pv, exp_locked, exp_stalled};
      n_tests++;
      if (got !== want || meas.period !== exp_period) begin
        n_fail++;
        $display("FAIL lock_cycle c=%0d got %b/%0d required %b/%0d", c, got, meas.period, want, exp_period);
      end
      if (meas.rise_tick === 1'b1) begin
        rise_c.push_back(c);
        if (rise_c.size() == 1) begin
          n_tests++;
          if (meas.period_valid !== 1'b0 || meas.locked !== 1'b0) begin
            n_fail++;
            $display("FAIL lock_first_rise got pv=%b locked=%b required pv=0 locked=0", meas.period_valid, meas.locked);
          end
        end
        if (rise_c.size() == 2) begin
          n_tests++;
          if (meas.period !== PW'(8) || meas.period_valid !== 1'b1 || meas.locked !== 1'b1) begin
            n_fail++;
            $display("FAIL lock_second_rise got period=%0d pv=%b locked=%b required 8/1/1", meas.period, meas.period_valid, meas.locked);
          end
        end
      end
      if (meas.fall_tick === 1'b1) fall_c.push_back(c);
    end
    // The sampling edge counts as the first of the three edges.
    n_tests++;
    if (rise_c.size() != 4 || rise_c[0] - first_high != 2) begin
      n_fail++;
      $display("FAIL lock_rise_latency got rises=%0d delay=%0d required rises=4 delay=2",
               rise_c.size(), (rise_c.size() > 0) ? rise_c[0] - first_high : -1);
    end
    n_tests++;
    if (fall_c.size() != 4) begin
      n_fail++;
      $display("FAIL lock_fall_count got %0d required 4", fall_c.size());
    end
    for (int k = 0; k < 4; k++) begin
      if (k < fall_c.size() && k < rise_c.size()) begin
        n_tests++;
        if (fall_c[k] - rise_c[k] != 4) begin
          n_fail++;
          $display("FAIL lock_fall_offset k=%0d got %0d required 4", k, fall_c[k] - rise_c[k]);
        end
      end
    end
  endtask

  task automatic test_period_change();
    logic [5:0] got, want;
    int pv_periods[$];
    for (int p = 0; p < 5; p++) begin
      for (int i = 0; i < 12; i++) begin
        step(i < 6);
        got  = {meas.level, meas.rise_tick, meas.fall_tick, meas.period_valid, meas.locked, meas.stalled};
        want = {exp_level, exp_rise, exp_fall, exp_pv, exp_locked, exp_stalled};
        n_tests++;
        if (got !== want || meas.period !== exp_period || meas.locked !== 1'b1) begin
          n_fail++;
          $display("FAIL period_change_cycle p=%0d i=%0d got %b/%0d required %b/%0d locked=1",
                   p, i, got, meas.period, want, exp_period);
        end
        if (meas.period_valid === 1'b1) pv_periods.push_back(int'(meas.period));
      end
    end
    n_tests++;
    if (pv_periods.size() < 4) begin
      n_fail++;
      $display("FAIL period_change_updates got %0d required >=4", pv_periods.size());
    end
    for (int k = 1; k < pv_periods.size(); k++) begin
      n_tests++;
      if (pv_periods[k] != 12) begin
        n_fail++;
        $display("FAIL period_change_value k=%0d got %0d required 12", k, pv_periods[k]);
      end
    end
  endtask

  task automatic test_timeout();
    logic [5:0] got, want;
    int c = 0;
    int last_rise_c = -1;
    int nr = 0;
    bit seen_stall = 0;
    for (int p = 0; p < 3; p++) begin
      for (int i = 0; i < 8; i++) begin
        c++;
        step(i < 4);
        if (meas.rise_tick === 1'b1) last_rise_c = c;
      end
    end
    for (int i = 0; i < 100 && !seen_stall; i++) begin
      c++;
      step(1'b0);
      got  = {meas.level, meas.rise_tick, meas.fall_tick, meas.period_valid, meas.locked, meas.stalled};
      want = {exp_level, exp_rise, exp_fall, exp_pv, exp_locked, exp_stalled};
      n_tests++;
      if (got !== want || meas.period !== exp_period) begin
        n_fail++;
        $display("FAIL timeout_cycle c=%0d got %b/%0d required %b/%0d", c, got, meas.period, want, exp_period);
      end
      if (meas.stalled === 1'b1) begin
        seen_stall = 1;
        n_tests++;
        if (c - last_rise_c != TIMEOUT || meas.locked !== 1'b0 || meas.period !== PW'(8)) begin
          n_fail++;
          $display("FAIL timeout_stall got delay=%0d locked=%b period=%0d required %0d/0/8",
                   c - last_rise_c, meas.locked, meas.period, TIMEOUT);
        end
      end
    end
    n_tests++;
    if (!seen_stall) begin
      n_fail++;
      $display("FAIL timeout_expired got stalled=0 required stalled=1 within 100 cycles");
    end
    for (int p = 0; p < 3; p++) begin
      for (int i = 0; i < 8; i++) begin
        step(i < 4);
        got  = {meas.level, meas.rise_tick, meas.fall_tick, meas.period_valid, meas.locked, meas.stalled};
        want = {exp_level, exp_rise, exp_fall, exp_pv, exp_locked, exp_stalled};
        n_tests++;
        if (got !== want || meas.period !== exp_period) begin
          n_fail++;
          $display("FAIL resume_cycle p=%0d i=%0d got %b/%0d required %b/%0d", p, i, got, meas.period, want, exp_period);
        end
        if (meas.rise_tick === 1'b1) begin
          nr++;
          n_tests++;
          if (nr == 1 && {meas.stalled, meas.locked, meas.period_valid} !== 3'b000) begin
            n_fail++;
            $display("FAIL resume_first_rise got st/lk/pv=%b required 000", {meas.stalled, meas.locked, meas.period_valid});
          end else if (nr >= 2 && {meas.stalled, meas.locked, meas.period_valid} !== 3'b011) begin
            n_fail++;
            $display("FAIL resume_relock nr=%0d got st/lk/pv=%b required 011", nr, {meas.stalled, meas.locked, meas.period_valid});
          end
        end
      end
    end
  endtask

  task automatic test_high_at_reset();
    logic [5:0] got, want;
    int rises = 0;
    reset = 1'b0;
    step(1'b1);
    step(1'b1);
    reset = 1'b1;
    for (int c = 1; c <= 8; c++) begin
      step(1'b1);
      got  = {meas.level, meas.rise_tick, meas.fall_tick, meas.period_valid, meas.locked, meas.stalled};
      want = {exp_level, exp_rise, exp_fall, exp_pv, exp_locked, exp_stalled};
      n_tests++;
      if (got !== want || meas.period !== exp_period) begin
        n_fail++;
        $display("FAIL high_reset_cycle c=%0d got %b/%0d required %b/%0d", c, got, meas.period, want, exp_period);
      end
      if (meas.rise_tick === 1'b1) rises++;
      n_tests++;
      if (meas.rise_tick !== (c == 3) || meas.period_valid !== 1'b0 || meas.locked !== 1'b0) begin
        n_fail++;
        $display("FAIL high_reset_tick c=%0d got rise=%b pv=%b locked=%b required rise=%b pv=0 locked=0",
                 c, meas.rise_tick, meas.period_valid, meas.locked, c == 3);
      end
    end
    n_tests++;
    if (rises != 1) begin
      n_fail++;
      $display("FAIL high_reset_count got %0d required 1", rises);
    end
  endtask

  task automatic test_mid_lock_reset();
    logic [5:0] got, want;
    int nr = 0;
    for (int i = 0; i < 5; i++) step(1'b0);
    for (int p = 0; p < 3; p++)
      for (int i = 0; i < 10; i++) step(i < 5);
    n_tests++;
    if (meas.locked !== 1'b1) begin
      n_fail++;
      $display("FAIL midreset_prelock got locked=%b required 1", meas.locked);
    end
    slow_in = 1'b1;
    #2;
    reset = 1'b0;
    #1;
    got = {meas.level, meas.rise_tick, meas.fall_tick, meas.period_valid, meas.locked, meas.stalled};
    n_tests++;
    if (got !== 6'b0 || meas.period !== '0) begin
      n_fail++;
      $display("FAIL midreset_clear got %b/%0d required 000000/0", got, meas.period);
    end
    @(posedge clock);
    #1;
    reset = 1'b1;
    for (int p = 0; p < 3; p++) begin
      for (int i = 0; i < 10; i++) begin
        step(i >= 5);
        got  = {meas.level, meas.rise_tick, meas.fall_tick, meas.period_valid, meas.locked, meas.stalled};
        want = {exp_level, exp_rise, exp_fall, exp_pv, exp_locked, exp_stalled};
        n_tests++;
        if (got !== want || meas.period !== exp_period) begin
          n_fail++;
          $display("FAIL midreset_cycle p=%0d i=%0d got %b/%0d required %b/%0d", p, i, got, meas.period, want, exp_period);
        end
        if (meas.rise_tick === 1'b1) begin
          nr++;
          n_tests++;
          if (meas.locked !== (nr >= 2)) begin
            n_fail++;
            $display("FAIL midreset_relock nr=%0d got locked=%b required %b", nr, meas.locked, nr >= 2);
          end
        end
      end
    end
  endtask

  task automatic test_random();
    logic [5:0] got, want;
    logic lvl = 1'b1;
    int w;
    for (int s = 0; s < 60; s++) begin
      w = ($urandom_range(0, 9) == 0) ? int'($urandom_range(65, 90)) : int'($urandom_range(1, 12));
      for (int i = 0; i < w; i++) begin
        step(lvl);
        got  = {meas.level, meas.rise_tick, meas.fall_tick, meas.period_valid, meas.locked, meas.stalled};
        want = {exp_level, exp_rise, exp_fall, exp_pv, exp_locked, exp_stalled};
        n_tests++;
        if (got !== want || meas.period !== exp_period) begin
          n_fail++;
          $display("FAIL random_cycle s=%0d w=%0d i=%0d got %b/%0d required %b/%0d", s, w, i, got, meas.period, want, exp_period);
        end
      end
      lvl = ~lvl;
    end
  endtask

  initial begin
    @(posedge clock);
    #1;
    test_reset();
    test_lock();
    test_period_change();
    test_timeout();
    test_high_at_reset();
    test_mid_lock_reset();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog got no completion required finish before 50000 cycles");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/edge_period_meter.md
# edge_period_meter

Measures the slow divided-clock signals produced by the ripple clock divider, from the receiving side in the 100 MHz system domain. The block synchronises an asynchronous slow square wave, emits single-cycle rising and falling ticks, and measures the rising-edge period in system clock cycles. It raises a stall flag when the slow signal stops toggling. It feeds the display-refresh and scan logic, and provides self-check of the divider chain.

## Interface
- SYNC_STAGES, 2: synchroniser depth; legal values are ≥2.
- PERIOD_WIDTH, 24: width of the period counter and the period output.
- TIMEOUT, 2**22: number of cycles without a rising edge before stall. Must satisfy 2 ≤ TIMEOUT ≤ 2**PERIOD_WIDTH-1.

- clock  in  1  system clock; all flops on the rising edge.
- reset  in  1  asynchronous, active-low; clears every flop, including the synchroniser.
- slow_in  in  1  slow signal, asynchronous to clock.
- level  out  1  synchronised copy of slow_in.
- rise_tick  out  1  one-cycle pulse per rising edge of level.
- fall_tick  out  1  one-cycle pulse per falling edge of level.
- period  out  PERIOD_WIDTH  clock cycles between the last two rise_ticks; holds its value between updates.
- period_valid  out  1  one-cycle pulse when period updates.
- locked  out  1  high while two or more consecutive rise_ticks have occurred without a timeout.
- stalled  out  1  sticky timeout flag; cleared by the next rise_tick or by reset.

## Operation
- The synchroniser is a SYNC_STAGES-deep flop chain. Its last stage is level.
- A prev flop holds the previous level.
  - rise_tick is registered from (level & ~prev).
  - fall_tick is registered from (~level & prev).
- Cycle counter cnt:
  - Cleared to 0 on the cycle rise_tick asserts.
  - Otherwise increments by 1 per cycle while the state is ARMED or LOCKED.
  - Held at 0 in IDLE.
  - Never wraps, because TIMEOUT bounds it.
- FSM states are IDLE, ARMED and LOCKED. The reset state is IDLE.
  - IDLE, on rise: go to ARMED. Clear stalled. Period is not updated.
  - ARMED, on rise: go to LOCKED. Set period = cnt+1 and pulse period_valid.
  - LOCKED, on rise: stay in LOCKED. Set period = cnt+1 and pulse period_valid.
  - ARMED or LOCKED, with cnt == TIMEOUT-1 and no rise: go to IDLE. Set stalled = 1. Period holds its value.
- locked = (state == LOCKED).
- If a rise and the timeout fall in the same cycle, the rise wins: no stall, normal transition.
- A level pulse of one system cycle still produces both ticks. No glitch filtering is performed.
- Reset clears everything asynchronously, mid-operation included. The synchroniser restarts from 0.
  - If slow_in is high when reset releases, a rise_tick follows. The FSM goes to ARMED, with no period_valid.

## Timing
- Reset values: level, rise_tick, fall_tick, period_valid, locked and stalled are all 0. period is 0. State is IDLE.
- Let slow_in go high before clock edge E1 with setup met:
  - level goes high after edge E(SYNC_STAGES).
  - rise_tick is high for exactly the one cycle after edge E(SYNC_STAGES+1).
  - Falling edges follow the same timing for fall_tick.
- period, period_valid, the locked transition and the stalled clear all update on the same edge as rise_tick.
- Latency from a slow_in edge to its tick is SYNC_STAGES+1 cycles, ±1 cycle of sampling uncertainty.
- stalled asserts exactly TIMEOUT cycles after the last rise_tick cycle. locked deasserts on the same edge.
- A square wave with period P ≥ 2 cycles produces period = P on every update after lock.

## Test plan
- Reset:
  - Stimulus: reset low for 5 cycles while slow_in toggles.
  - Required: all outputs 0 throughout. period = 0.
- Lock (SYNC_STAGES=2):
  - Stimulus: release reset, then drive 4 cycles high / 4 cycles low.
  - First rise_tick: 3 edges after the first high sample. FSM goes to ARMED, no period_valid.
  - Second rise_tick: period = 8, one-cycle period_valid, locked = 1.
  - fall_tick: 4 cycles after each rise_tick.
- Period change:
  - Stimulus: switch to 6 high / 6 low.
  - Required: the first updated measurement may be intermediate; every update after it has period = 12. locked stays 1.
- Timeout (TIMEOUT=64):
  - Stimulus: hold slow_in low after lock.
  - Required: stalled = 1 and locked = 0 exactly 64 cycles after the last rise_tick. period still 8.
  - Stimulus: resume toggling.
  - Required: the next rise_tick clears stalled and goes to ARMED. locked returns on the following rise_tick.
- High at reset release:
  - Stimulus: slow_in held high and reset released.
  - Required: one rise_tick after 3 edges, no period_valid, locked = 0.
- Mid-lock reset:
  - Stimulus: assert reset asynchronously between clock edges while locked.
  - Required: every output clears immediately, before the next clock edge. Relock requires two new rise_ticks.
